snn_image_loader: RTL
=====================

# snn_image_loader

Front-end initiator for `snn_core`. Accepts a 784-pixel binary image as 98 packed bytes from the UART receiver and unpacks it into the 1-bit input-unit RAM. It then pulses `start`, waits for `done`, captures `digit`, and sends the result back through the UART transmitter. It is the write side and start/done initiator of the interface that `snn_core` reads and answers.

## Interface
- `NUM_PIXELS`, 784: pixels per image; must be a multiple of 8.
- `ADDR_W`, 10: input-RAM address width.
- `clk` in 1: system clock, all logic on the rising edge.
- `rst_n` in 1: reset, asynchronous assert, active-low.
- `rx_rdy` in 1: one-cycle pulse, `rx_data` valid.
- `rx_data` in 8: received byte; bit i is pixel 8k+i (LSB first).
- `ram_we` out 1: input-RAM write enable.
- `ram_addr` out ADDR_W: input-RAM write address.
- `ram_data` out 1: pixel bit written.
- `start` out 1: one-cycle pulse to `snn_core`.
- `done` in 1: one-cycle pulse from `snn_core`.
- `digit` in 4: classification result, valid in the `done` cycle.
- `tx_busy` in 1: transmitter busy.
- `tx_start` out 1: one-cycle pulse to begin transmission.
- `tx_data` out 8: byte to transmit.
- `result` out 4: last captured digit, held.
- `overrun` out 1: sticky error flag.

## Operation
- States:
  - LOAD: wait for a byte.
  - UNPACK: 8 cycles, one pixel written per cycle.
  - START: `start`=1 for one cycle.
  - WAIT_DONE: wait for `done`.
  - TX_WAIT: wait for `tx_busy`=0.
  - TX: `tx_start`=1 for one cycle.
- LOAD:
  - `rx_rdy` loads `rx_data` into the shift register; go to UNPACK.
  - If the hold register is valid, it loads from hold instead.
- UNPACK:
  - Each cycle: `ram_we`=1, `ram_data`=shift[0], `ram_addr`=pixel counter.
  - Shift right, increment the pixel counter.
  - After bit 7, if the pixel counter reached NUM_PIXELS, go to START. Otherwise:
    - hold valid: reload from hold and stay in UNPACK (no gap);
    - hold empty: go to LOAD.
- Hold register (one entry):
  - Captures `rx_rdy` during UNPACK.
  - `rx_rdy` while hold is already valid: byte dropped, `overrun`=1.
- Entering START:
  - A valid hold is discarded and sets `overrun`.
  - The pixel counter clears.
- Outside LOAD/UNPACK: `rx_rdy` is dropped and sets `overrun`.
- WAIT_DONE:
  - `done` latches `digit` into `result`; go to TX_WAIT.
  - `done` in any other state is ignored.
- TX_WAIT: when `tx_busy`=0, go to TX. TX presents `tx_data` from `result`, then returns to LOAD.
- `overrun` clears only on reset.

## Timing
- Reset values: `ram_we`=0, `ram_addr`=0, `ram_data`=0, `start`=0, `tx_start`=0, `tx_data`=0, `result`=0, `overrun`=0, state LOAD.
- Counters and hold cleared at reset.
- All outputs are registered.
- Byte accepted at cycle N: `ram_we` high for cycles N+1..N+8, addresses 8k..8k+7.
- Last pixel (addr NUM_PIXELS-1) written at cycle M: `start` high at M+1.
- `done` at cycle D: `result` valid at D+1.
- `tx_start` asserts no earlier than D+2, and only in a cycle following `tx_busy`=0.
- Back-to-back bytes: sustained throughput is 1 byte per 8 cycles with no bubble when hold is pre-filled.
- `rx_rdy` coincident with the bit-7 write goes to hold, not overrun.
- Reset mid-frame aborts the frame. Partial RAM contents are left as-is; the next frame restarts at addr 0.

## Configuration
- `LOADER_ASCII_EN` defined: `tx_data` = 8'h30 + `result` (ASCII '0'..'9').
- Not defined: `tx_data` = {4'h0, `result`}.
- No other behaviour changes.

## Structure
- Package `snn_loader_pkg` holds:
  - the state enum `loader_state_t`;
  - localparams NUM_PIXELS, NUM_BYTES (= NUM_PIXELS/8), ASCII_ZERO (8'h30).
- Single module with no sub-module; shift and hold registers are inline.

## Test plan
- 98 bytes 8'hA5, spaced 20 cycles → 784 writes, pattern 1,0,1,0,0,1,0,1 per byte; one `start`, one cycle after the write to addr 783.
- Bytes every 8 cycles (hold path) → contiguous `ram_we` for 784 cycles; `overrun`=0.
- Three `rx_rdy` pulses inside one UNPACK window → third byte dropped, `overrun`=1, addresses still contiguous for the accepted bytes.
- `done` with `digit`=7, `tx_busy` high 50 cycles → `result`=7; `tx_start` one cycle after `tx_busy` falls; `tx_data`=8'h37 with `LOADER_ASCII_EN`, 8'h07 without.
- `rst_n` low after 40 bytes, then a full frame → writes restart at addr 0, exactly one `start`.
- `done` pulsed during LOAD → ignored, `result` unchanged, no `tx_start`.

Source files
------------

// File: rtl/snn_loader_pkg.sv
// Shared types and constants for the snn_core image loader.
package snn_loader_pkg;

  localparam int         NUM_PIXELS = 784;
  localparam int         NUM_BYTES  = NUM_PIXELS / 8;
  localparam logic [7:0] ASCII_ZERO = 8'h30;

  typedef enum logic [2:0] {
    ST_LOAD,
    ST_UNPACK,
    ST_START,
    ST_WAIT_DONE,
    ST_TX_WAIT,
    ST_TX
  } loader_state_t;

endpackage

// File: rtl/snn_image_loader.sv
// Unpacks a UART-delivered binary image into the snn_core input RAM, runs the core, returns the digit.
// Define LOADER_ASCII_EN to transmit the result as ASCII '0'..'9' instead of a raw nibble.
module snn_image_loader #(
  parameter int NUM_PIXELS = snn_loader_pkg::NUM_PIXELS,
  parameter int ADDR_W     = 10
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              rx_rdy,
  input  logic [7:0]        rx_data,
  output logic              ram_we,
  output logic [ADDR_W-1:0] ram_addr,
  output logic              ram_data,
  output logic              start,
  input  logic              done,
  input  logic [3:0]        digit,
  input  logic              tx_busy,
  output logic              tx_start,
  output logic [7:0]        tx_data,
  output logic [3:0]        result,
  output logic              overrun
);
  import snn_loader_pkg::*;

  loader_state_t     r_state, w_state;
  logic [7:0]        r_shift, w_shift;
  logic [2:0]        r_bit, w_bit;
  logic [ADDR_W-1:0] r_pix, w_pix;
  logic [7:0]        r_hold, w_hold;
  logic              r_hold_vld, w_hold_vld;
  logic              r_ram_we, w_ram_we;
  logic [ADDR_W-1:0] r_ram_addr, w_ram_addr;
  logic              r_ram_data, w_ram_data;
  logic              r_start, w_start;
  logic              r_tx_start, w_tx_start;
  logic [7:0]        r_tx_data, w_tx_data;
  logic [3:0]        r_result, w_result;
  logic              r_overrun, w_overrun;

  logic [7:0]        w_src;
  logic              w_last_pix;
  logic              w_consume;
  logic [7:0]        w_tx_byte;

`ifdef LOADER_ASCII_EN
  assign w_tx_byte = ASCII_ZERO + {4'h0, r_result};
`else
  assign w_tx_byte = {4'h0, r_result};
`endif

  assign w_src      = r_hold_vld ? r_hold : rx_data;
  assign w_last_pix = (r_pix == ADDR_W'(NUM_PIXELS - 1));
  // The hold byte is taken over at the end of the current byte, freeing the slot for a new rx byte.
  assign w_consume  = (r_state == ST_UNPACK) && (r_bit == 3'd7) && !w_last_pix && r_hold_vld;

  // RAM outputs are computed one cycle ahead so the write lands the cycle after the byte is accepted.
  always_comb begin
    w_state    = r_state;
    w_shift    = r_shift;
    w_bit      = r_bit;
    w_pix      = r_pix;
    w_hold     = r_hold;
    w_hold_vld = r_hold_vld;
    w_ram_we   = 1'b0;
    w_ram_addr = r_ram_addr;
    w_ram_data = r_ram_data;
    w_start    = 1'b0;
    w_tx_start = 1'b0;
    w_tx_data  = r_tx_data;
    w_result   = r_result;
    w_overrun  = r_overrun;

    case (r_state)
      ST_LOAD: begin
        if (r_hold_vld || rx_rdy) begin
          w_ram_we   = 1'b1;
          w_ram_addr = r_pix;
          w_ram_data = w_src[0];
          w_shift    = {1'b0, w_src[7:1]};
          w_bit      = 3'd1;
          w_pix      = r_pix + ADDR_W'(1);
          w_state    = ST_UNPACK;
          if (r_hold_vld) begin
            w_hold_vld = rx_rdy;
            if (rx_rdy) w_hold = rx_data;
          end
        end
      end

      ST_UNPACK: begin
        w_ram_we   = 1'b1;
        w_ram_addr = r_pix;
        w_ram_data = r_shift[0];
        w_shift    = {1'b0, r_shift[7:1]};
        w_bit      = r_bit + 3'd1;
        w_pix      = r_pix + ADDR_W'(1);

        if (w_consume) w_hold_vld = 1'b0;
        if (rx_rdy) begin
          if (r_hold_vld && !w_consume) begin
            w_overrun = 1'b1;
          end else begin
            w_hold     = rx_data;
            w_hold_vld = 1'b1;
          end
        end

        if (r_bit == 3'd7) begin
          if (w_last_pix) begin
            w_state    = ST_START;
            w_pix      = '0;
            w_hold_vld = 1'b0;
            if (r_hold_vld || rx_rdy) w_overrun = 1'b1;
          end else if (r_hold_vld) begin
            w_shift = r_hold;
            w_bit   = 3'd0;
          end else begin
            w_state = ST_LOAD;
          end
        end
      end

      ST_START: begin
        w_start = 1'b1;
        w_state = ST_WAIT_DONE;
      end

      ST_WAIT_DONE: begin
        if (done) begin
          w_result = digit;
          w_state  = ST_TX_WAIT;
        end
      end

      ST_TX_WAIT: begin
        if (!tx_busy) begin
          w_tx_start = 1'b1;
          w_tx_data  = w_tx_byte;
          w_state    = ST_TX;
        end
      end

      ST_TX: begin
        w_state = ST_LOAD;
      end

      default: begin
        w_state = ST_LOAD;
      end
    endcase

    if (rx_rdy && (r_state != ST_LOAD) && (r_state != ST_UNPACK)) w_overrun = 1'b1;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state    <= ST_LOAD;
      r_shift    <= '0;
      r_bit      <= '0;
      r_pix      <= '0;
      r_hold     <= '0;
      r_hold_vld <= 1'b0;
      r_ram_we   <= 1'b0;
      r_ram_addr <= '0;
      r_ram_data <= 1'b0;
      r_start    <= 1'b0;
      r_tx_start <= 1'b0;
      r_tx_data  <= '0;
      r_result   <= '0;
      r_overrun  <= 1'b0;
    end else begin
      r_state    <= w_state;
      r_shift    <= w_shift;
      r_bit      <= w_bit;
      r_pix      <= w_pix;
      r_hold     <= w_hold;
      r_hold_vld <= w_hold_vld;
      r_ram_we   <= w_ram_we;
      r_ram_addr <= w_ram_addr;
      r_ram_data <= w_ram_data;
      r_start    <= w_start;
      r_tx_start <= w_tx_start;
      r_tx_data  <= w_tx_data;
      r_result   <= w_result;
      r_overrun  <= w_overrun;
    end
  end

  assign ram_we   = r_ram_we;
  assign ram_addr = r_ram_addr;
  assign ram_data = r_ram_data;
  assign start    = r_start;
  assign tx_start = r_tx_start;
  assign tx_data  = r_tx_data;
  assign result   = r_result;
  assign overrun  = r_overrun;

endmodule
